// File: rtl/tt_pkg.sv
// Shared types and configuration for the truth-table extractor.
package tt_pkg;

    localparam int unsigned N_IN_DEF   = 8;
    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned IDX_W      = N_IN_DEF;
    localparam int unsigned N_WORDS    = (32'd1 << N_IN_DEF) / WORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } tt_state_e;

    // Word width must be a power of two (at least 2) that divides the sweep length.
    function automatic bit cfg_ok(input int unsigned n_in, input int unsigned word_w);
        return (n_in >= 1) && (n_in <= 30) && (word_w >= 2) &&
               ((word_w & (word_w - 1)) == 0) && (word_w <= (32'd1 << n_in));
    endfunction

endpackage

// File: rtl/tt_word_packer.sv
// Assembles sampled response bits into words and holds them on a valid/ready output.
module tt_word_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned POS_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [POS_W-1:0]  bit_pos,
    input  logic              bit_in,
    input  logic              last_pat,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              stall_c
);

    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_next_c;
    logic              word_end_c;

    always_comb begin
        asm_next_c          = asm_q;
        asm_next_c[bit_pos] = bit_in;
    end

    assign word_end_c = (bit_pos == POS_W'(WORD_W - 1));
    // A completing word may not overwrite one the sink has not yet taken.
    assign stall_c    = word_end_c && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (capture) begin
                asm_q <= asm_next_c;
            end
            if (capture && word_end_c) begin
                out_data  <= asm_next_c;
                out_valid <= 1'b1;
                out_last  <= last_pat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tt_extractor.sv
// Sweeps all input patterns of a combinational cell and streams its truth table.
module tt_extractor
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = IDX_W,
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [N_IN:0]     ones_cnt,
    output logic              done
);

    localparam int unsigned POS_W = $clog2(WORD_W);

    if (!cfg_ok(N_IN, WORD_W)) begin : g_cfg_err
        $error("tt_extractor: WORD_W must be a power of two >= 2 and <= 2**N_IN");
    end

    tt_state_e state;
    tt_state_e state_next;
    logic      stall_c;
    logic      capture_c;
    logic      last_pat_c;
    logic      accept_c;
    logic      drain_hs_c;

    assign last_pat_c = &dut_in;
    assign capture_c  = (state == SWEEP) && !stall_c;
    // A start coinciding with the done pulse belongs to the finished sweep.
    assign accept_c   = (state == IDLE) && start && !done;
    assign drain_hs_c = (state == DRAIN) && out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = SWEEP;
            SWEEP:   if (capture_c && last_pat_c) state_next = DRAIN;
            DRAIN:   if (drain_hs_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pattern counter wraps to 0 on the final capture, leaving dut_in at 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in   <= '0;
            ones_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= drain_hs_c;
            if (accept_c) begin
                dut_in   <= '0;
                ones_cnt <= '0;
                busy     <= 1'b1;
            end else if (capture_c) begin
                dut_in   <= dut_in + N_IN'(1);
                ones_cnt <= ones_cnt + (N_IN + 1)'(dut_out);
            end
            if (drain_hs_c) begin
                busy <= 1'b0;
            end
        end
    end

    tt_word_packer #(
        .WORD_W (WORD_W),
        .POS_W  (POS_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture_c),
        .bit_pos   (dut_in[POS_W-1:0]),
        .bit_in    (dut_out),
        .last_pat  (last_pat_c),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .stall_c   (stall_c)
    );

endmodule

// File: tb/tb_tt_extractor.sv
// Randomized self-checking bench for tt_extractor against a pattern-level truth-table model.
module tb_tt_extractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [7:0]  dut_in;
    logic        dut_out;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [8:0]  ones_cnt;
    logic        done;

    logic        start4;
    logic        busy4;
    logic [3:0]  dut_in4;
    logic        dut_out4;
    logic [15:0] out_data4;
    logic        out_valid4;
    logic        out_ready4;
    logic        out_last4;
    logic [4:0]  ones_cnt4;
    logic        done4;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cell_mode = 1;
    bit [255:0]  lut;

    logic [31:0] got_data[$];
    bit          got_last[$];
    int          stab_viol = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data;
    logic        pend_last;

    int          stall_bad;
    int          stall_dut_in;
    int          first_valid_edge;

    always #5 clk = ~clk;

    tt_extractor u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .ones_cnt  (ones_cnt),
        .done      (done)
    );

    tt_extractor #(.N_IN(4), .WORD_W(16)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .busy      (busy4),
        .dut_in    (dut_in4),
        .dut_out   (dut_out4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_last  (out_last4),
        .ones_cnt  (ones_cnt4),
        .done      (done4)
    );

    // Cells under test
    always_comb begin
        case (cell_mode)
            0:       dut_out = (&dut_in[3:0]) & ~(&dut_in[7:4]);
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            3:       dut_out = dut_in[0];
            default: dut_out = lut[dut_in];
        endcase
    end
    assign dut_out4 = ^dut_in4;

    // Reference model: response of a cell to pattern number p
    function automatic bit ref_cell(input int mode, input int p);
        case (mode)
            0:       return (p % 16 == 15) && (p / 16 != 15);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (p % 2) == 1;
            default: return lut[p];
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int mode, input int w);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = ref_cell(mode, w * 32 + k);
        return r;
    endfunction

    function automatic int ref_ones(input int mode);
        int s;
        s = 0;
        for (int p = 0; p < 256; p++) s += int'(ref_cell(mode, p));
        return s;
    endfunction

    // Handshake monitor and hold-while-stalled tracker
    always @(negedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend && (!out_valid || out_data !== pend_data || out_last !== pend_last))
                stab_viol <= stab_viol + 1;
            pend      <= out_valid && !out_ready;
            pend_data <= out_data;
            pend_last <= out_last;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
        end
    end

    // Runs one sweep; mode 0 ready high, 1 random ready, 2 ready low 50 cycles after first valid
    task automatic sweep(input int mode, input bit poke_start, output int done_edge);
        int edges;
        bit seen;
        edges = 0;
        seen = 1'b0;
        done_edge = -1;
        stall_bad = 0;
        stall_dut_in = -1;
        first_valid_edge = -1;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && edges < 3000) begin
            @(posedge clk); #1;
            edges++;
            start = poke_start && (edges == 40);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (first_valid_edge >= 0) && (edges > first_valid_edge + 50);
            endcase
            @(negedge clk);
            if (mode == 2) begin
                if (first_valid_edge < 0 && out_valid) first_valid_edge = edges;
                if (out_valid && out_data !== 32'hAAAAAAAA) stall_bad++;
                if (first_valid_edge >= 0 && edges == first_valid_edge + 50) stall_dut_in = int'(dut_in);
            end
            if (done) begin
                seen = 1'b1;
                done_edge = edges;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if ({busy, dut_in, out_valid, out_last, out_data, ones_cnt, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b dut_in=%h valid=%b last=%b data=%h ones=%h done=%b, required all 0",
                     busy, dut_in, out_valid, out_last, out_data, ones_cnt, done);
        end
        n_tests++;
        if ({busy4, out_valid4, out_data4, ones_cnt4, done4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs4: busy=%b valid=%b data=%h ones=%h done=%b, required all 0",
                     busy4, out_valid4, out_data4, ones_cnt4, done4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dut_in !== 8'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b dut_in=%h valid=%b, required 0/00/0", busy, dut_in, out_valid);
        end
    endtask

    task automatic test_and_nand();
        int de;
        logic [31:0] g;
        bit [7:0] lastv;
        cell_mode = 0;
        got_data.delete();
        got_last.delete();
        sweep(0, 1'b0, de);
        n_tests++;
        if (de !== 257) begin
            n_fail++;
            $display("FAIL and_nand_done_edge: done after edge %0d, required 257", de);
        end
        n_tests++;
        if (got_data.size() !== 8) begin
            n_fail++;
            $display("FAIL and_nand_count: %0d words, required 8", got_data.size());
        end
        lastv = '0;
        for (int w = 0; w < 8; w++) begin
            g = (w < got_data.size()) ? got_data[w] : 32'hx;
            if (w < got_last.size()) lastv[w] = got_last[w];
            n_tests++;
            if (g !== ref_word(0, w)) begin
                n_fail++;
                $display("FAIL and_nand_word%0d: got %h, required %h", w, g, ref_word(0, w));
            end
        end
        n_tests++;
        if (lastv !== 8'h80) begin
            n_fail++;
            $display("FAIL and_nand_last: last flags %b, required 10000000", lastv);
        end
        n_tests++;
        if (ones_cnt !== 9'(ref_ones(0)) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL and_nand_ones_busy: ones=%0d busy=%b, required %0d/0", ones_cnt, busy, ref_ones(0));
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || ones_cnt !== 9'd15) begin
            n_fail++;
            $display("FAIL and_nand_done_pulse: done=%b ones=%0d one cycle later, required 0/15", done, ones_cnt);
        end
    endtask

    task automatic test_constants();
        int de;
        logic [31:0] g;
        for (int m = 1; m <= 2; m++) begin
            cell_mode = m;
            got_data.delete();
            got_last.delete();
            sweep(0, 1'b0, de);
            n_tests++;
            if (got_data.size() !== 8 || de !== 257) begin
                n_fail++;
                $display("FAIL const%0d_count: %0d words done_edge %0d, required 8/257", m - 1, got_data.size(), de);
            end
            for (int w = 0; w < 8; w++) begin
                g = (w < got_data.size()) ? got_data[w] : 32'hx;
                n_tests++;
                if (g !== ref_word(m, w)) begin
                    n_fail++;
                    $display("FAIL const%0d_word%0d: got %h, required %h", m - 1, w, g, ref_word(m, w));
                end
            end
            n_tests++;
            if (ones_cnt !== 9'(ref_ones(m))) begin
                n_fail++;
                $display("FAIL const%0d_ones: got %0d, required %0d", m - 1, ones_cnt, ref_ones(m));
            end
        end
    endtask

    task automatic test_backpressure();
        int de;
        int sv0;
        logic [31:0] g;
        cell_mode = 3;
        got_data.delete();
        got_last.delete();
        sv0 = stab_viol;
        sweep(2, 1'b0, de);
        n_tests++;
        if (de < 0) begin
            n_fail++;
            $display("FAIL stall_timeout: done never seen, required a done pulse");
        end
        n_tests++;
        if (stall_bad !== 0 || stab_viol !== sv0) begin
            n_fail++;
            $display("FAIL stall_data_hold: %0d bad words %0d unstable cycles, required 0/0", stall_bad, stab_viol - sv0);
        end
        n_tests++;
        if (stall_dut_in !== 63) begin
            n_fail++;
            $display("FAIL stall_dut_in: got %0d, required 63", stall_dut_in);
        end
        n_tests++;
        if (got_data.size() !== 8) begin
            n_fail++;
            $display("FAIL stall_count: %0d words, required 8", got_data.size());
        end
        for (int w = 0; w < 8; w++) begin
            g = (w < got_data.size()) ? got_data[w] : 32'hx;
            n_tests++;
            if (g !== 32'hAAAAAAAA) begin
                n_fail++;
                $display("FAIL stall_word%0d: got %h, required aaaaaaaa", w, g);
            end
        end
    endtask

    task automatic test_random();
        int de;
        int sv0;
        logic [31:0] g;
        bit [7:0] lastv;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) lut[i*32 +: 32] = $urandom;
            cell_mode = 4;
            got_data.delete();
            got_last.delete();
            sv0 = stab_viol;
            sweep(1, 1'b0, de);
            n_tests++;
            if (de < 0 || got_data.size() !== 8) begin
                n_fail++;
                $display("FAIL rand%0d_count: done_edge %0d words %0d, required done and 8", r, de, got_data.size());
            end
            lastv = '0;
            for (int w = 0; w < 8; w++) begin
                g = (w < got_data.size()) ? got_data[w] : 32'hx;
                if (w < got_last.size()) lastv[w] = got_last[w];
                n_tests++;
                if (g !== ref_word(4, w)) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got %h, required %h", r, w, g, ref_word(4, w));
                end
            end
            n_tests++;
            if (lastv !== 8'h80 || ones_cnt !== 9'(ref_ones(4)) || stab_viol !== sv0) begin
                n_fail++;
                $display("FAIL rand%0d_misc: last %b ones %0d unstable %0d, required 10000000/%0d/0",
                         r, lastv, ones_cnt, stab_viol - sv0, ref_ones(4));
            end
        end
    endtask

    task automatic test_mid_reset();
        int de;
        int n;
        logic [31:0] g;
        for (int i = 0; i < 8; i++) lut[i*32 +: 32] = $urandom;
        cell_mode = 4;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (dut_in !== 8'd100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 500) begin
            n_fail++;
            $display("FAIL mid_reset_reach: dut_in=%0d, required to reach 100", dut_in);
        end
        rst_n = 1'b0;
        got_data.delete();
        got_last.delete();
        #1;
        n_tests++;
        if ({busy, dut_in, out_valid, out_last, out_data, ones_cnt, done} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: busy=%b dut_in=%h valid=%b last=%b data=%h ones=%h done=%b, required all 0",
                     busy, dut_in, out_valid, out_last, out_data, ones_cnt, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (got_data.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: %0d words busy=%b after release, required 0/0", got_data.size(), busy);
        end
        sweep(0, 1'b0, de);
        n_tests++;
        if (de !== 257 || got_data.size() !== 8 || ones_cnt !== 9'(ref_ones(4))) begin
            n_fail++;
            $display("FAIL mid_reset_restart: done_edge %0d words %0d ones %0d, required 257/8/%0d",
                     de, got_data.size(), ones_cnt, ref_ones(4));
        end
        for (int w = 0; w < 8; w++) begin
            g = (w < got_data.size()) ? got_data[w] : 32'hx;
            n_tests++;
            if (g !== ref_word(4, w)) begin
                n_fail++;
                $display("FAIL mid_reset_word%0d: got %h, required %h", w, g, ref_word(4, w));
            end
        end
    endtask

    task automatic test_ignore_start();
        int de;
        cell_mode = 3;
        got_data.delete();
        got_last.delete();
        sweep(0, 1'b1, de);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (de !== 257 || got_data.size() !== 8) begin
            n_fail++;
            $display("FAIL ignore_start_sweep: done_edge %0d words %0d, required 257/8", de, got_data.size());
        end
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || dut_in !== 8'd0) begin
            n_fail++;
            $display("FAIL ignore_start_idle: busy=%b valid=%b dut_in=%0d, required 0/0/0", busy, out_valid, dut_in);
        end
    endtask

    task automatic test_param_variant();
        int n;
        int cnt;
        bit seen;
        logic [15:0] w4;
        logic [15:0] exp4;
        logic l4;
        int ones4;
        ones4 = 0;
        for (int k = 0; k < 16; k++) begin
            exp4[k] = ($countones(k) % 2) == 1;
            ones4 += int'(exp4[k]);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        cnt = 0;
        seen = 1'b0;
        w4 = 'x;
        l4 = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid4 && out_ready4) begin
                w4 = out_data4;
                l4 = out_last4;
                cnt++;
            end
            if (done4) seen = 1'b1;
        end
        n_tests++;
        if (!seen || n !== 18) begin
            n_fail++;
            $display("FAIL param_done: seen=%b at sample %0d, required 1 at 18", seen, n);
        end
        n_tests++;
        if (cnt !== 1 || w4 !== exp4 || l4 !== 1'b1) begin
            n_fail++;
            $display("FAIL param_word: %0d words data %h last %b, required 1/%h/1", cnt, w4, exp4, l4);
        end
        n_tests++;
        if (ones_cnt4 !== 5'(ones4)) begin
            n_fail++;
            $display("FAIL param_ones: got %0d, required %0d", ones_cnt4, ones4);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start4 = 1'b0;
        out_ready = 1'b0;
        out_ready4 = 1'b1;
        lut = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_and_nand();
        test_constants();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_ignore_start();
        test_param_variant();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_extractor.md
# tt_extractor

Sequential truth-table extractor for the regression flow. It sweeps every input pattern of an 8-input combinational cell under test, such as an AND-tree gate netlist, and samples the cell's single output. It packs the sampled bits into fixed-width truth-table words and streams them out over a valid/ready interface, together with an on-set (ones) count. It recovers a functional description from a netlist, so the flow can compare synthesized results against golden truth tables.

## Interface
Parameters:
- N_IN, 8, input count of the cell under test; sweep length is 2^N_IN.
- WORD_W, 32, output word width. Must be a power of two and must be ≤ 2^N_IN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep. Ignored while busy.
- busy  out  1  high from start acceptance until done.
- dut_in  out  N_IN  registered pattern driven to the cell under test.
- dut_out  in  1  combinational response of the cell to dut_in.
- out_data  out  WORD_W  truth-table word. Bit k is the response to pattern (word_index·WORD_W + k).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word.
- out_last  out  1  marks the final word; qualified by out_valid.
- ones_cnt  out  N_IN+1  number of patterns with response 1. Stable from done until the next start.
- done  out  1  single-cycle pulse after the last word handshakes.

## Operation
- States: IDLE, SWEEP, DRAIN.
- IDLE:
  - Holds dut_in at 0.
  - start=1 → SWEEP: pattern counter cleared, ones_cnt cleared, busy set.
- SWEEP: at each non-stalled edge:
  - Write dut_out into bit (idx mod WORD_W) of the assembly register.
  - Add dut_out to ones_cnt.
  - Increment idx and drive it on dut_in.
- Word completion (idx mod WORD_W = WORD_W−1):
  - The assembled word, including the bit being captured, loads into out_data.
  - out_valid is set next cycle.
  - On the final pattern, out_last is also set and the state goes to DRAIN.
- Stall:
  - Applies when a word would complete while out_valid=1 and out_ready=0.
  - idx, dut_in, the assembly register and ones_cnt all hold.
  - Capture resumes once the pending word is accepted; a handshake and a new load in the same cycle is legal.
- DRAIN:
  - Waits for the out_last handshake.
  - On handshake: done pulses for one cycle, busy drops, state returns to IDLE.
- Counter width: idx is N_IN bits and wraps to 0 after the final pattern. The wrap is never used as a terminal condition; the last-pattern flag is.
- ones_cnt saturates by construction; its maximum is 2^N_IN, which fits in N_IN+1 bits.
- Output protocol: out_data and out_last are stable while out_valid=1 and out_ready=0.
- Reset, including mid-sweep, forces:
  - state IDLE
  - busy=0, dut_in=0, out_valid=0, out_last=0, out_data=0, ones_cnt=0, done=0.
  - No partial word is emitted after reset.

## Timing
- Edge E0 accepts start. dut_in=0 is driven after E0.
- Edge Ek captures the response to pattern k−1.
- With out_ready held high:
  - Word w gets out_valid after edge E(WORD_W·(w+1)).
  - The last word is valid after E(2^N_IN).
  - done pulses one cycle after the last handshake.
- Total with no stalls: 2^N_IN + 2 cycles from start to done (258 cycles for the defaults).
- dut_in is registered, so the cell has one full clock period to settle.
- A start asserted in the same cycle as done is ignored.

## Structure
- Shared package tt_pkg holds:
  - the state enum (IDLE/SWEEP/DRAIN);
  - localparams N_WORDS = 2^N_IN/WORD_W and IDX_W = N_IN;
  - the elaboration-time check that WORD_W is a power of two and divides 2^N_IN.
- Sub-module tt_word_packer holds the assembly register, the bit-position decode and the out_data/out_valid/out_last holding register with its valid/ready logic.
- The top level holds the FSM, the pattern counter and the ones counter.

## Test plan
- AND-NAND cell: dut_out = &dut_in[3:0] & ~&dut_in[7:4], out_ready=1.
  - Required: words 0–6 = 0x80008000, word 7 = 0x00008000, out_last only on word 7, ones_cnt=15.
  - Required: done pulses at cycle 258 after start.
- Constant-0 cell, then constant-1 cell.
  - Required: eight words of 0x00000000 with ones_cnt=0, then eight words of 0xFFFFFFFF with ones_cnt=256 (0x100).
- Identity on dut_in[0], with out_ready low for 50 cycles after the first valid.
  - Required: out_data stays at 0xAAAAAAAA throughout.
  - Required: dut_in freezes at 63 (pattern 63 being the one that would complete word 1) until the handshake; total word count is still 8.
- rst_n pulsed low at pattern 100 during a sweep.
  - Required: all outputs go to 0 immediately; a restart yields a clean full sweep with correct words.
- start pulsed during SWEEP and again in the done cycle.
  - Required: both are ignored; exactly one sweep of 8 words.
- Parameter variant N_IN=4, WORD_W=16, with a parity cell (dut_out = ^dut_in).
  - Required: a single word 0x6996 with out_last=1 and ones_cnt=8.
